// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control block.
// State encoding, default debounce/lap-hold tick counts, counter sizing helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_e;

    localparam int DEB_TICKS_DEF      = 20;
    localparam int LAP_HOLD_TICKS_DEF = 3000;

    // Bits needed to count 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, tick-based debounce,
// and a single-clk press pulse on the debounced rising edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = cnt_width(DEB_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic          meta_q;
    logic          meta_d;
    logic          sync_q;
    logic          sync_d;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Next-state: synchronize, then count stable ticks while the input
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
        meta_d  = btn_raw;
        sync_d  = meta_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync_q == deb_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync_q;
                cnt_d   = '0;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register synchronizer, debounce state and the press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: IDLE/RUN/LAP/PAUSE driven by two debounced buttons.
// Optional macro LAP_AUTORELEASE_EN: leave LAP after LAP_HOLD_TICKS ticks.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_TICKS      = DEB_TICKS_DEF,
    parameter int LAP_HOLD_TICKS = LAP_HOLD_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    if (DEB_TICKS < 1 || LAP_HOLD_TICKS < 1) begin : g_bad_param
        $error("stopwatch_ctrl: DEB_TICKS and LAP_HOLD_TICKS must be >= 1");
    end

    logic press_ss;
    logic press_lr;

    btn_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_deb_ss (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_raw (btn_ss),
        .press   (press_ss)
    );

    btn_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_deb_lr (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_raw (btn_lr),
        .press   (press_lr)
    );

    sw_state_e state_q;
    sw_state_e state_d;
    logic      count_en_q;
    logic      count_en_d;
    logic      count_clr_q;
    logic      count_clr_d;
    logic      disp_hold_q;
    logic      disp_hold_d;

`ifdef LAP_AUTORELEASE_EN
    localparam int HW = cnt_width(LAP_HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LAP_HOLD_TICKS - 1);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
`endif

    // Next-state and output decode; start/stop always beats lap/reset,
    // and outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        count_clr_d = 1'b0;
`ifdef LAP_AUTORELEASE_EN
        hold_d      = hold_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (press_ss) begin
                    state_d = ST_RUN;
                end else if (press_lr) begin
                    state_d     = ST_IDLE;
                    count_clr_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (press_ss) begin
                    state_d = ST_PAUSE;
                end else if (press_lr) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (press_ss) begin
                    state_d = ST_PAUSE;
                end else if (press_lr) begin
                    state_d = ST_RUN;
                end
`ifdef LAP_AUTORELEASE_EN
                else if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
            end
            ST_PAUSE: begin
                if (press_ss) begin
                    state_d = ST_RUN;
                end else if (press_lr) begin
                    state_d     = ST_IDLE;
                    count_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef LAP_AUTORELEASE_EN
        if (state_d == ST_LAP && state_q != ST_LAP) begin
            hold_d = '0;
        end
`endif
        count_en_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
        disp_hold_d = (state_d == ST_LAP);
    end

    // FSM register with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            disp_hold_q <= 1'b0;
`ifdef LAP_AUTORELEASE_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            disp_hold_q <= disp_hold_d;
`ifdef LAP_AUTORELEASE_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
    assign disp_hold = disp_hold_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DEB_TICKS=4, LAP_HOLD_TICKS=10,
// tick every 8 clk). Honours LAP_AUTORELEASE_EN when defined.
module tb_stopwatch_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_LAP   = 2;
    localparam int S_PAUSE = 3;

`ifdef LAP_AUTORELEASE_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       count_en;
    logic       count_clr;
    logic       disp_hold;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    int clr_seen = 0;
    int mstate = S_IDLE;

    // Spec transition table, indexed by current state.
    int ss_next[4] = '{S_RUN, S_PAUSE, S_PAUSE, S_RUN};
    int lr_next[4] = '{S_IDLE, S_LAP, S_RUN, S_IDLE};

    stopwatch_ctrl #(
        .DEB_TICKS      (4),
        .LAP_HOLD_TICKS (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_ss    (btn_ss),
        .btn_lr    (btn_lr),
        .count_en  (count_en),
        .count_clr (count_clr),
        .disp_hold (disp_hold),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 7);
            tcnt = (tcnt + 1) % 8;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && count_clr) begin
            clr_seen++;
            chk("clr_in_idle", int'(state), S_IDLE);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input int exp_clr);
        chk({tag, ".state"}, int'(state), mstate);
        chk({tag, ".count_en"}, int'(count_en),
            (mstate == S_RUN || mstate == S_LAP) ? 1 : 0);
        chk({tag, ".disp_hold"}, int'(disp_hold),
            (mstate == S_LAP) ? 1 : 0);
        chk({tag, ".clr_pulses"}, clr_seen, exp_clr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        mstate = S_IDLE;
    endtask

    // kind: 0 press ss, 1 press lr, 2 both, 3 short glitch, 4 quiet.
    // Each op lasts ~12 ticks, so a LAP entered in one op always
    // times out (when enabled) early in the next, before its press lands.
    task automatic run_op(input string tag, input int kind);
        int exp_clr;
        int g;
        exp_clr = 0;
        if (AR && mstate == S_LAP) mstate = S_RUN;
        @(posedge clk);
        #1;
        clr_seen = 0;
        if (kind == 3) begin
            g = $urandom_range(1, 15);
            if ($urandom_range(0, 1) == 1) btn_ss = 1'b1;
            else btn_lr = 1'b1;
            wait_clk(g);
            btn_ss = 1'b0;
            btn_lr = 1'b0;
            wait_clk(96 - g);
        end else begin
            btn_ss = (kind == 0 || kind == 2);
            btn_lr = (kind == 1 || kind == 2);
            wait_clk(48);
            btn_ss = 1'b0;
            btn_lr = 1'b0;
            wait_clk(48);
        end
        if (kind == 0 || kind == 2) begin
            mstate = ss_next[mstate];
        end else if (kind == 1) begin
            exp_clr = (mstate == S_IDLE || mstate == S_PAUSE) ? 1 : 0;
            mstate = lr_next[mstate];
        end
        @(negedge clk);
        chk_outputs(tag, exp_clr);
    endtask

    initial begin
        bit found;

        wait_clk(3);
        @(negedge clk);
        chk("rst.state", int'(state), S_IDLE);
        chk("rst.count_en", int'(count_en), 0);
        chk("rst.count_clr", int'(count_clr), 0);
        chk("rst.disp_hold", int'(disp_hold), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clk(8);

        clr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            btn_ss = 1'b1;
            wait_clk(16);
            btn_ss = 1'b0;
            wait_clk(16);
        end
        wait_clk(48);
        @(negedge clk);
        chk_outputs("bounce", 0);

        @(posedge clk);
        #1;
        btn_ss = 1'b1;
        wait_clk(24);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(20);
        @(negedge clk);
        chk("rst_mid.state", int'(state), S_IDLE);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (state == 2'(S_RUN)) found = 1'b1;
        end
        chk("first_press.seen", int'(found), 1);
        chk("first_press.count_en", int'(count_en), 1);
        chk("first_press.disp_hold", int'(disp_hold), 0);
        btn_ss = 1'b0;
        wait_clk(48);
        mstate = S_RUN;

        run_op("run_lr", 1);
        run_op("lap_lr", 1);
        run_op("run_ss", 0);
        run_op("pause_lr", 1);
        run_op("idle_ss", 0);
        run_op("run_both", 2);
        run_op("pause_ss", 0);
        run_op("glitch", 3);

        do_reset();
        run_op("hold_ss", 0);
        run_op("hold_lr", 1);
        wait_clk(800);
        mstate = AR ? S_RUN : S_LAP;
        @(negedge clk);
        chk("lap_hold.state", int'(state), mstate);
        chk("lap_hold.disp_hold", int'(disp_hold), AR ? 0 : 1);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
